// File: rtl/rename_table_pkg.sv
// Shared definitions for the register rename block: architectural/physical
// sizes, tag type and free-list geometry.
package rename_table_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_TAGS = 64;
  localparam int TAG_W     = $clog2(PHYS_TAGS);
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int SLOTS     = 2;
  // Tags 0..ARCH_REGS-1 start out mapped; the rest start on the free list.
  localparam int FL_DEPTH  = PHYS_TAGS - ARCH_REGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int FL_CNT_W  = FL_PTR_W + 1;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [AREG_W-1:0] areg_t;
endpackage

// File: rtl/rename_table_if.sv
// Rename interface bundle: per-slot queries (q_*), combinational responses
// (r_*, stall), writeback broadcast (cdb_*) and commit release (ret_*).
// master = pipeline side driving queries, slave = the rename table.
interface rename_table_if;
  import rename_table_pkg::*;
  areg_t [SLOTS-1:0] q_rs1, q_rs2, q_rd;
  logic  [SLOTS-1:0] q_rename;
  tag_t  [SLOTS-1:0] r_rs1_tag, r_rs2_tag, r_rd_tag, r_rd_old_tag;
  logic  [SLOTS-1:0] r_rs1_busy, r_rs2_busy;
  logic              stall;
  logic              cdb_valid;
  tag_t              cdb_tag;
  logic  [SLOTS-1:0] ret_valid;
  tag_t  [SLOTS-1:0] ret_tag;

  modport master (output q_rs1, q_rs2, q_rd, q_rename, cdb_valid, cdb_tag, ret_valid, ret_tag,
                  input  r_rs1_tag, r_rs2_tag, r_rd_tag, r_rd_old_tag, r_rs1_busy, r_rs2_busy, stall);
  modport slave  (input  q_rs1, q_rs2, q_rd, q_rename, cdb_valid, cdb_tag, ret_valid, ret_tag,
                  output r_rs1_tag, r_rs2_tag, r_rd_tag, r_rd_old_tag, r_rs1_busy, r_rs2_busy, stall);
endinterface

// File: rtl/rename_table_free_list.sv
// tag_free_list: 2-push / 2-pop circular FIFO of free physical tags.
// Ports: clk, reset_n (async low), flush (sync restore), push_en/push_tag
// (slot 0 written first), pop_n (0..2 tags taken from head), head_tag
// (entries at head and head+1), count (occupancy 0..FL_DEPTH).
module tag_free_list
  import rename_table_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [1:0]          push_en,
  input  tag_t [1:0]          push_tag,
  input  logic [1:0]          pop_n,
  output tag_t [1:0]          head_tag,
  output logic [FL_CNT_W-1:0] count
);
  typedef logic [FL_PTR_W-1:0] ptr_t;

  tag_t [FL_DEPTH-1:0] fifo_q, fifo_d;
  ptr_t                head_q, head_d, tail_q, tail_d, tail1;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic [1:0]          n_push;

  assign head_tag[0] = fifo_q[head_q];
  assign head_tag[1] = fifo_q[head_q + ptr_t'(1)];
  assign count       = count_q;

  always_comb begin
    n_push  = {1'b0, push_en[0]} + {1'b0, push_en[1]};
    // Slot 1 lands after slot 0 only when slot 0 actually pushed.
    tail1   = tail_q + ptr_t'(push_en[0]);
    fifo_d  = fifo_q;
    if (push_en[0]) fifo_d[tail_q] = push_tag[0];
    if (push_en[1]) fifo_d[tail1]  = push_tag[1];
    // Pointers are FL_PTR_W bits wide, so they wrap modulo FL_DEPTH for free.
    head_d  = head_q + ptr_t'(pop_n);
    tail_d  = tail_q + ptr_t'(n_push);
    count_d = count_q + FL_CNT_W'(n_push) - FL_CNT_W'(pop_n);
    if (flush) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo_d[i] = tag_t'(ARCH_REGS + i);
      head_d  = '0;
      tail_d  = '0;
      count_d = FL_CNT_W'(FL_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo_q[i] <= tag_t'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A full list can never legally receive a released tag.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !((|push_en) && count_q == FL_CNT_W'(FL_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    FL_CNT_W'(pop_n) <= count_q);
endmodule

// File: rtl/rename_table.sv
// rename_table: 2-wide register rename map with busy tracking and free list.
// Ports: clk, reset_n (async low), flush (sync restore to reset state),
// rt (rename_table_if.slave): queries in, combinational tags/busy/stall out,
// cdb writeback clears busy, ret_* return tags to the free list.
module rename_table
  import rename_table_pkg::*;
#(
  parameter int ARCH_REGS = rename_table_pkg::ARCH_REGS,
  parameter int PHYS_TAGS = rename_table_pkg::PHYS_TAGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  rename_table_if.slave rt
);
  tag_t                map_q [ARCH_REGS];
  tag_t                map_d [ARCH_REGS];
  logic [PHYS_TAGS-1:0] busy_q, busy_d;

  logic [1:0]          need, push_en, n_need, pop_n;
  logic                stall, alloc;
  tag_t [1:0]          fl_head, new_tag;
  logic [FL_CNT_W-1:0] fl_count;

  // Busy unless this cycle's writeback carries the tag.
  function automatic logic src_busy(input tag_t t, input logic [PHYS_TAGS-1:0] bv,
                                    input logic cv, input tag_t ct);
    return bv[t] && !(cv && ct == t);
  endfunction

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      need[s]    = rt.q_rename[s] && rt.q_rd[s] != '0;
      push_en[s] = !flush && rt.ret_valid[s] && rt.ret_tag[s] != '0;
    end
    n_need = {1'b0, need[0]} + {1'b0, need[1]};
    stall  = !flush && (fl_count < FL_CNT_W'(n_need));
    alloc  = !flush && !stall;
    pop_n  = alloc ? n_need : 2'd0;
    // A lone slot-1 requester still takes the head.
    new_tag[0] = fl_head[0];
    new_tag[1] = need[0] ? fl_head[1] : fl_head[0];
  end

  tag_free_list u_fl (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push_en  (push_en),
    .push_tag (rt.ret_tag),
    .pop_n    (pop_n),
    .head_tag (fl_head),
    .count    (fl_count)
  );

  // Responses
  always_comb begin
    rt.stall        = stall;
    rt.r_rs1_tag    = '0;
    rt.r_rs2_tag    = '0;
    rt.r_rs1_busy   = '0;
    rt.r_rs2_busy   = '0;
    rt.r_rd_tag     = '0;
    rt.r_rd_old_tag = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (rt.q_rs1[s] != '0) begin
        rt.r_rs1_tag[s]  = map_q[rt.q_rs1[s]];
        rt.r_rs1_busy[s] = src_busy(map_q[rt.q_rs1[s]], busy_q, rt.cdb_valid, rt.cdb_tag);
      end
      if (rt.q_rs2[s] != '0) begin
        rt.r_rs2_tag[s]  = map_q[rt.q_rs2[s]];
        rt.r_rs2_busy[s] = src_busy(map_q[rt.q_rs2[s]], busy_q, rt.cdb_valid, rt.cdb_tag);
      end
      rt.r_rd_tag[s]     = need[s] ? new_tag[s] : '0;
      rt.r_rd_old_tag[s] = map_q[rt.q_rd[s]];
    end
    // Slot 1 sees slot 0's rename as if it were already in the map.
    if (need[0]) begin
      if (rt.q_rs1[1] == rt.q_rd[0]) begin
        rt.r_rs1_tag[1]  = new_tag[0];
        rt.r_rs1_busy[1] = 1'b1;
      end
      if (rt.q_rs2[1] == rt.q_rd[0]) begin
        rt.r_rs2_tag[1]  = new_tag[0];
        rt.r_rs2_busy[1] = 1'b1;
      end
      if (rt.q_rd[1] == rt.q_rd[0]) rt.r_rd_old_tag[1] = new_tag[0];
    end
  end

  // Next state: clear from writeback first so a same-tag allocation wins.
  always_comb begin
    map_d  = map_q;
    busy_d = busy_q;
    if (rt.cdb_valid && rt.cdb_tag != '0) busy_d[rt.cdb_tag] = 1'b0;
    if (alloc) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (need[s]) begin
          map_d[rt.q_rd[s]]   = new_tag[s];
          busy_d[new_tag[s]] = 1'b1;
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) map_d[i] = tag_t'(i);
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= tag_t'(i);
      busy_q <= '0;
    end else begin
      map_q  <= map_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_rename_table.sv
module tb_rename_table;
  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  rename_table_if rif ();

  rename_table u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .rt      (rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     sel;
    int     slot;
    integer exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int S_STALL = 0, S_RS1T = 1, S_RS1B = 2, S_RS2T = 3, S_RS2B = 4,
                 S_RDT = 5, S_OLD = 6, S_CNT = 7, S_HEAD = 8;

  function automatic integer obs(input int sel, input int slot);
    case (sel)
      S_STALL: return integer'(rif.stall);
      S_RS1T:  return integer'(rif.r_rs1_tag[slot]);
      S_RS1B:  return integer'(rif.r_rs1_busy[slot]);
      S_RS2T:  return integer'(rif.r_rs2_tag[slot]);
      S_RS2B:  return integer'(rif.r_rs2_busy[slot]);
      S_RDT:   return integer'(rif.r_rd_tag[slot]);
      S_OLD:   return integer'(rif.r_rd_old_tag[slot]);
      S_CNT:   return integer'(u_dut.u_fl.count_q);
      S_HEAD:  return integer'(u_dut.u_fl.head_q);
      default: return 'x;
    endcase
  endfunction

  task automatic push_exp(input string n, input int sel, input int slot, input integer v);
    sb.push_back('{n, sel, slot, v});
  endtask

  task automatic check_now();
    exp_t   e;
    integer got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.sel, e.slot);
      checks++;
      assert (got === e.exp) else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", e.name, got, e.exp);
      end
    end
  endtask

  task automatic idle();
    flush         = 1'b0;
    rif.q_rs1     = '0;
    rif.q_rs2     = '0;
    rif.q_rd      = '0;
    rif.q_rename  = '0;
    rif.cdb_valid = 1'b0;
    rif.cdb_tag   = '0;
    rif.ret_valid = '0;
    rif.ret_tag   = '0;
  endtask

  // Inputs are already driven; compare mid-cycle, then move past the edge.
  task automatic step();
    #3 check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    idle();
  endtask

  int mfree[$];
  int mmap[32];
  int r0, r1, n0, n1, o0, o1, p0, p1;

  initial begin
    reset_n = 1'b0;
    idle();
    rif.q_rs1[0] = 5'd5;
    #12;
    push_exp("rst_rs1_tag", S_RS1T, 0, 5);
    push_exp("rst_rs1_busy", S_RS1B, 0, 0);
    push_exp("rst_stall", S_STALL, 0, 0);
    push_exp("rst_count", S_CNT, 0, 32);
    push_exp("rst_head", S_HEAD, 0, 0);
    check_now();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // First allocation after reset
    idle();
    rif.q_rd[0] = 5'd5; rif.q_rename = 2'b01;
    push_exp("a_rd_tag", S_RDT, 0, 32);
    push_exp("a_old_tag", S_OLD, 0, 5);
    push_exp("a_stall", S_STALL, 0, 0);
    step();
    idle();
    rif.q_rs1[0] = 5'd5;
    push_exp("a_rs1_tag", S_RS1T, 0, 32);
    push_exp("a_rs1_busy", S_RS1B, 0, 1);
    step();

    // Intra-pair bypass, both slots renaming x3
    do_flush();
    rif.q_rd[0] = 5'd3; rif.q_rs1[1] = 5'd3; rif.q_rd[1] = 5'd3; rif.q_rename = 2'b11;
    push_exp("b_rd0_tag", S_RDT, 0, 32);
    push_exp("b_old0", S_OLD, 0, 3);
    push_exp("b_rs1_1_tag", S_RS1T, 1, 32);
    push_exp("b_rs1_1_busy", S_RS1B, 1, 1);
    push_exp("b_rd1_tag", S_RDT, 1, 33);
    push_exp("b_old1", S_OLD, 1, 32);
    step();
    idle();
    rif.q_rs1[0] = 5'd3;
    push_exp("b_map3", S_RS1T, 0, 33);
    push_exp("b_map3_busy", S_RS1B, 0, 1);
    push_exp("b_count", S_CNT, 0, 30);
    step();

    // Writeback forwarding and clear
    idle();
    rif.q_rs1[0] = 5'd3; rif.q_rs2[1] = 5'd3;
    rif.cdb_valid = 1'b1; rif.cdb_tag = 6'd33;
    push_exp("c_rs1_tag", S_RS1T, 0, 33);
    push_exp("c_rs1_busy", S_RS1B, 0, 0);
    push_exp("c_rs2_1_busy", S_RS2B, 1, 0);
    step();
    idle();
    rif.q_rs1[0] = 5'd3;
    push_exp("c_after_busy", S_RS1B, 0, 0);
    step();

    // Drain the free list with paired renames
    do_flush();
    for (int k = 0; k < 16; k++) begin
      idle();
      rif.q_rename = 2'b11;
      rif.q_rd[0]  = 5'(((2 * k) % 31) + 1);
      rif.q_rd[1]  = 5'(((2 * k + 1) % 31) + 1);
      push_exp("d_rd0", S_RDT, 0, 32 + 2 * k);
      push_exp("d_rd1", S_RDT, 1, 33 + 2 * k);
      push_exp("d_stall", S_STALL, 0, 0);
      step();
    end
    idle();
    rif.q_rename = 2'b10; rif.q_rd[1] = 5'd4;
    push_exp("d_empty_count", S_CNT, 0, 0);
    push_exp("d_empty_stall", S_STALL, 0, 1);
    step();
    idle();
    rif.q_rs1[0] = 5'd4;
    rif.q_rename = 2'b10; rif.q_rd[1] = 5'd4;
    rif.ret_valid = 2'b01; rif.ret_tag[0] = 6'd7;
    push_exp("d_stall_nochg_map4", S_RS1T, 0, 35);
    push_exp("d_stall_nochg_cnt", S_CNT, 0, 0);
    push_exp("d_ret_cycle_stall", S_STALL, 0, 1);
    step();
    idle();
    rif.q_rename = 2'b10; rif.q_rd[1] = 5'd4;
    push_exp("d_after_ret_stall", S_STALL, 0, 0);
    push_exp("d_alloc7", S_RDT, 1, 7);
    push_exp("d_old35", S_OLD, 1, 35);
    step();
    idle();
    rif.q_rs1[0] = 5'd4;
    push_exp("d_map4", S_RS1T, 0, 7);
    push_exp("d_map4_busy", S_RS1B, 0, 1);
    push_exp("d_cnt_end", S_CNT, 0, 0);
    step();

    // Flush beats rename and retire in the same cycle
    idle();
    flush = 1'b1;
    rif.q_rename = 2'b11; rif.q_rd[0] = 5'd9; rif.q_rd[1] = 5'd10;
    rif.ret_valid = 2'b01; rif.ret_tag[0] = 6'd40;
    push_exp("e_flush_stall", S_STALL, 0, 0);
    step();
    idle();
    rif.q_rs1[0] = 5'd9; rif.q_rs2[1] = 5'd10; rif.q_rs1[1] = 5'd4;
    push_exp("e_count", S_CNT, 0, 32);
    push_exp("e_head", S_HEAD, 0, 0);
    push_exp("e_map9", S_RS1T, 0, 9);
    push_exp("e_map9_busy", S_RS1B, 0, 0);
    push_exp("e_map10", S_RS2T, 1, 10);
    push_exp("e_map4", S_RS1T, 1, 4);
    push_exp("e_map4_busy", S_RS1B, 1, 0);
    step();

    // x0 destination and sources
    idle();
    rif.q_rename = 2'b01; rif.q_rd[0] = 5'd0;
    rif.cdb_valid = 1'b1; rif.cdb_tag = 6'd0;
    push_exp("f_x0_stall", S_STALL, 0, 0);
    push_exp("f_x0_rs1", S_RS1T, 0, 0);
    push_exp("f_x0_rs1_busy", S_RS1B, 0, 0);
    push_exp("f_x0_rs2", S_RS2T, 0, 0);
    push_exp("f_x0_rs2_busy", S_RS2B, 0, 0);
    step();
    idle();
    push_exp("f_x0_nopop", S_CNT, 0, 32);
    step();

    // Pointer wrap with continuous retire of displaced tags
    for (int i = 0; i < 32; i++) mmap[i] = i;
    for (int i = 32; i < 64; i++) mfree.push_back(i);
    p0 = 0; p1 = 0;
    for (int k = 0; k < 24; k++) begin
      idle();
      r0 = (k % 15) + 1;
      r1 = (k % 15) + 16;
      rif.q_rename = 2'b11;
      rif.q_rd[0] = 5'(r0);
      rif.q_rd[1] = 5'(r1);
      n0 = mfree.pop_front();
      n1 = mfree.pop_front();
      o0 = mmap[r0]; mmap[r0] = n0;
      o1 = mmap[r1]; mmap[r1] = n1;
      push_exp("g_rd0", S_RDT, 0, n0);
      push_exp("g_rd1", S_RDT, 1, n1);
      push_exp("g_old0", S_OLD, 0, o0);
      push_exp("g_old1", S_OLD, 1, o1);
      if (k > 0) begin
        rif.ret_valid  = 2'b11;
        rif.ret_tag[0] = 6'(p0);
        rif.ret_tag[1] = 6'(p1);
        mfree.push_back(p0);
        mfree.push_back(p1);
      end
      p0 = o0; p1 = o1;
      step();
    end
    idle();
    push_exp("g_count", S_CNT, 0, mfree.size());
    push_exp("g_head", S_HEAD, 0, 16);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
